// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM states, port identities
// and the SRAM tag constants carried with commands.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_RD = 2'd1,
    ST_GRANT_WR = 2'd2,
    ST_SWITCH   = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_RD = 1'b0,
    PORT_WR = 1'b1
  } port_e;

  // Tag values seen on the SRAM command/return path
  localparam logic [1:0] TAG_INVALID = 2'd0;
  localparam logic [1:0] TAG_DATA0   = 2'd1;
  localparam logic [1:0] TAG_DATA1   = 2'd2;
  localparam logic [1:0] TAG_END     = 2'd3;

  // Port that is not the given one (used for turnaround target selection)
  function automatic port_e other_port(input port_e p);
    if (p == PORT_RD) begin
      return PORT_WR;
    end else begin
      return PORT_RD;
    end
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one SRAM command port between a read port and a
// write port. Grants are held for bursts of up to MAX_BURST commands while
// the other port waits, with a one-cycle turnaround between directions.
// Commands are forwarded one cycle after acceptance; read returns are
// forwarded one cycle late regardless of grant state.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SRAMDATA_WIDTH = 32,
  parameter int TAG_WIDTH      = 2,
  parameter int MAX_BURST      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  // port 0: reads
  input  logic                      rd_cmd,
  input  logic [ADDRESS_WIDTH-1:0]  rd_addr,
  input  logic [TAG_WIDTH-1:0]      rd_tag,
  output logic                      rd_ready,
  output logic                      rd_valid,
  output logic [SRAMDATA_WIDTH-1:0] rd_data,
  output logic [TAG_WIDTH-1:0]      rd_qtag,
  // port 1: writes
  input  logic                      wr_cmd,
  input  logic [ADDRESS_WIDTH-1:0]  wr_addr,
  input  logic [SRAMDATA_WIDTH-1:0] wr_data,
  output logic                      wr_ready,
  // SRAM side
  output logic                      sram_cmd,
  output logic                      sram_we,
  output logic [ADDRESS_WIDTH-1:0]  sram_addr,
  output logic [SRAMDATA_WIDTH-1:0] sram_wdata,
  output logic [TAG_WIDTH-1:0]      sram_tag,
  input  logic                      sram_ready,
  input  logic                      sram_rvalid,
  input  logic [SRAMDATA_WIDTH-1:0] sram_rdata,
  input  logic [TAG_WIDTH-1:0]      sram_rtag
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  arb_state_e                r_state;
  logic [CNT_W-1:0]          r_burst_cnt;
  port_e                     r_last_grant;

  logic                      r_sram_cmd;
  logic                      r_sram_we;
  logic [ADDRESS_WIDTH-1:0]  r_sram_addr;
  logic [SRAMDATA_WIDTH-1:0] r_sram_wdata;
  logic [TAG_WIDTH-1:0]      r_sram_tag;

  logic                      r_rd_valid;
  logic [SRAMDATA_WIDTH-1:0] r_rd_data;
  logic [TAG_WIDTH-1:0]      r_rd_qtag;

  logic                      w_rd_acc;
  logic                      w_wr_acc;
  logic                      w_acc;
  logic                      w_own_cmd;
  logic                      w_oth_cmd;
  logic [CNT_W-1:0]          w_cnt_next;

  // Ready follows the grant, gated by the SRAM's own back-pressure
  assign rd_ready = (r_state == ST_GRANT_RD) & sram_ready;
  assign wr_ready = (r_state == ST_GRANT_WR) & sram_ready;

  assign w_rd_acc = rd_cmd & rd_ready;
  assign w_wr_acc = wr_cmd & wr_ready;
  assign w_acc    = w_rd_acc | w_wr_acc;

  // Pick out the granted port's request and the waiting port's request
  always_comb begin
    w_own_cmd = 1'b0;
    w_oth_cmd = 1'b0;
    case (r_state)
      ST_GRANT_RD: begin
        w_own_cmd = rd_cmd;
        w_oth_cmd = wr_cmd;
      end
      ST_GRANT_WR: begin
        w_own_cmd = wr_cmd;
        w_oth_cmd = rd_cmd;
      end
      default: begin
        w_own_cmd = 1'b0;
        w_oth_cmd = 1'b0;
      end
    endcase
  end

  // Burst count including this cycle's acceptance, saturating at MAX_BURST
  always_comb begin
    w_cnt_next = r_burst_cnt;
    if (w_acc && (r_burst_cnt != CNT_MAX)) begin
      w_cnt_next = r_burst_cnt + CNT_ONE;
    end else begin
      w_cnt_next = r_burst_cnt;
    end
  end

  // Grant FSM: idle arbitration, burst tracking and read/write turnaround
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_burst_cnt  <= {CNT_W{1'b0}};
      r_last_grant <= PORT_WR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // On a tie the port that was not served last wins
          if (rd_cmd && (!wr_cmd || (r_last_grant == PORT_WR))) begin
            r_state      <= ST_GRANT_RD;
            r_last_grant <= PORT_RD;
            r_burst_cnt  <= {CNT_W{1'b0}};
          end else if (wr_cmd) begin
            r_state      <= ST_GRANT_WR;
            r_last_grant <= PORT_WR;
            r_burst_cnt  <= {CNT_W{1'b0}};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT_RD, ST_GRANT_WR: begin
          // A stalled SRAM freezes the grant and its burst count
          if (sram_ready) begin
            r_burst_cnt <= w_cnt_next;
            if (w_oth_cmd && ((w_cnt_next == CNT_MAX) || !w_own_cmd)) begin
              r_state <= ST_SWITCH;
            end else if (!w_own_cmd && !w_oth_cmd) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= r_state;
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_SWITCH: begin
          r_burst_cnt  <= {CNT_W{1'b0}};
          r_last_grant <= other_port(r_last_grant);
          if (r_last_grant == PORT_RD) begin
            r_state <= ST_GRANT_WR;
          end else begin
            r_state <= ST_GRANT_RD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register the accepted command onto the SRAM port one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sram_cmd   <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= {ADDRESS_WIDTH{1'b0}};
      r_sram_wdata <= {SRAMDATA_WIDTH{1'b0}};
      r_sram_tag   <= {TAG_WIDTH{1'b0}};
    end else begin
      r_sram_cmd <= w_acc;
      if (w_wr_acc) begin
        r_sram_we    <= 1'b1;
        r_sram_addr  <= wr_addr;
        r_sram_wdata <= wr_data;
        r_sram_tag   <= TAG_WIDTH'(TAG_INVALID);
      end else if (w_rd_acc) begin
        r_sram_we   <= 1'b0;
        r_sram_addr <= rd_addr;
        r_sram_tag  <= rd_tag;
      end else begin
        r_sram_we <= 1'b0;
      end
    end
  end

  // Forward SRAM read returns to port 0, never gated by the grant
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= {SRAMDATA_WIDTH{1'b0}};
      r_rd_qtag  <= {TAG_WIDTH{1'b0}};
    end else begin
      r_rd_valid <= sram_rvalid;
      r_rd_data  <= sram_rdata;
      r_rd_qtag  <= sram_rtag;
    end
  end

  assign sram_cmd   = r_sram_cmd;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_tag   = r_sram_tag;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_qtag    = r_rd_qtag;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios with
// cycle-exact expectations plus a randomized run against a behavioural model.
module tb_sram_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TW   = 2;
  localparam int MAXB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd_cmd, wr_cmd, sram_ready, sram_rvalid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data, sram_rdata;
  logic [TW-1:0] rd_tag, sram_rtag;
  logic          rd_ready, wr_ready, rd_valid, sram_cmd, sram_we;
  logic [DW-1:0] rd_data, sram_wdata;
  logic [TW-1:0] rd_qtag, sram_tag;
  logic [AW-1:0] sram_addr;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the SRAM (0 none, 1 read, 2 write), turnaround pending,
  // commands served this grant, and which port was granted most recently.
  int      m_owner = 0;
  bit      m_turn  = 1'b0;
  int      m_cnt   = 0;
  int      m_last  = 2;
  bit      e_cmd = 1'b0, e_we = 1'b0, e_rv = 1'b0;
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  logic [TW-1:0] e_tag   = '0, e_rq = '0;

  sram_port_arbiter #(
    .ADDRESS_WIDTH(AW), .SRAMDATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_BURST(MAXB)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_qtag(rd_qtag),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .sram_cmd(sram_cmd), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_tag(sram_tag), .sram_ready(sram_ready),
    .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata), .sram_rtag(sram_rtag)
  );

  always #5 clock = ~clock;

  function automatic bit m_rd_rdy();
    return (m_owner == 1) && !m_turn && (sram_ready == 1'b1);
  endfunction

  function automatic bit m_wr_rdy();
    return (m_owner == 2) && !m_turn && (sram_ready == 1'b1);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit ra, wa, own, oth;
    ra = rd_cmd && m_rd_rdy();
    wa = wr_cmd && m_wr_rdy();
    if (reset) begin
      m_owner = 0; m_turn = 1'b0; m_cnt = 0; m_last = 2;
      e_cmd = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_tag = '0;
      e_rv = 1'b0; e_rdata = '0; e_rq = '0;
      return;
    end
    e_cmd = ra || wa;
    if (wa) begin
      e_we = 1'b1; e_addr = wr_addr; e_wdata = wr_data; e_tag = '0;
    end else if (ra) begin
      e_we = 1'b0; e_addr = rd_addr; e_tag = rd_tag;
    end
    e_rv = sram_rvalid; e_rdata = sram_rdata; e_rq = sram_rtag;
    if (m_turn) begin
      m_owner = 3 - m_owner; m_turn = 1'b0; m_cnt = 0; m_last = m_owner;
    end else if (m_owner == 0) begin
      if (rd_cmd && wr_cmd) m_owner = 3 - m_last;
      else if (rd_cmd) m_owner = 1;
      else if (wr_cmd) m_owner = 2;
      if (m_owner != 0) begin
        m_cnt = 0; m_last = m_owner;
      end
    end else if (sram_ready) begin
      own = (m_owner == 1) ? rd_cmd : wr_cmd;
      oth = (m_owner == 1) ? wr_cmd : rd_cmd;
      if (ra || wa) m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
      if (oth && (m_cnt >= MAXB || !own)) m_turn = 1'b1;
      else if (!own && !oth) m_owner = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rd_cmd = 1'b0; wr_cmd = 1'b0; sram_ready = 1'b1; sram_rvalid = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; sram_rdata = '0;
    rd_tag = '0; sram_rtag = '0;
  endtask

  task automatic start_fresh();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [104:0] obs;
    idle_inputs();
    rd_cmd = 1'b1; wr_cmd = 1'b1; sram_rvalid = 1'b1;
    sram_rdata = 32'hDEAD_BEEF; sram_rtag = 2'd3; rd_addr = 32'h55; wr_addr = 32'h66;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    obs = {sram_cmd, sram_we, sram_addr, sram_wdata, sram_tag,
           rd_valid, rd_data, rd_qtag, rd_ready, wr_ready};
    checks++;
    if (obs !== 105'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({rd_ready, wr_ready, sram_cmd} !== 3'b000) begin
      failures++; $display("FAIL reset_idle got=%b exp=000", {rd_ready, wr_ready, sram_cmd});
    end
    tick();
  endtask

  task automatic test_read_stream();
    int idx, pulses, first_rdy;
    int acc_cyc[$];
    bit accepted;
    start_fresh();
    idx = 0; pulses = 0; first_rdy = 0;
    rd_cmd = 1'b1; rd_addr = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock);
      if (rd_ready && first_rdy == 0) first_rdy = cyc;
      if (sram_cmd) begin
        checks++;
        if (sram_we !== 1'b0 || sram_addr !== AW'(pulses) || acc_cyc.size() == 0 ||
            acc_cyc[0] != cyc - 1) begin
          failures++;
          $display("FAIL rd_stream_pulse cyc=%0d got we=%b addr=%0d exp we=0 addr=%0d", cyc,
                   sram_we, sram_addr, pulses);
        end
        if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
        pulses++;
      end
      accepted = rd_cmd && rd_ready;
      if (accepted) acc_cyc.push_back(cyc);
      tick();
      if (accepted) begin
        idx++;
        rd_addr = AW'(idx);
        if (idx == 6) rd_cmd = 1'b0;
      end
    end
    checks++;
    if (first_rdy != 2) begin
      failures++; $display("FAIL rd_stream_first_ready got=%0d exp=2", first_rdy);
    end
    checks++;
    if (pulses != 6) begin
      failures++; $display("FAIL rd_stream_pulses got=%0d exp=6", pulses);
    end
  endtask

  task automatic test_both_hold();
    string exp_s;
    byte   obs;
    exp_s = "-RRRR-WWWW-RR";
    start_fresh();
    rd_cmd = 1'b1; wr_cmd = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      rd_addr = $urandom; wr_addr = $urandom; wr_data = $urandom;
      @(negedge clock);
      if (rd_ready && rd_cmd) obs = "R";
      else if (wr_ready && wr_cmd) obs = "W";
      else obs = "-";
      checks++;
      if (obs !== exp_s[cyc-1]) begin
        failures++;
        $display("FAIL both_hold cyc=%0d got=%c exp=%c", cyc, obs, exp_s[cyc-1]);
      end
      tick();
    end
  endtask

  task automatic test_write_drop();
    string exp_s;
    byte   obs;
    exp_s = ".www.rrrr.w";
    start_fresh();
    for (int cyc = 1; cyc <= 11; cyc++) begin
      wr_cmd = (cyc <= 3 || cyc >= 6);
      rd_cmd = (cyc >= 2);
      @(negedge clock);
      if (rd_ready && wr_ready) obs = "x";
      else if (rd_ready) obs = "r";
      else if (wr_ready) obs = "w";
      else obs = ".";
      checks++;
      if (obs !== exp_s[cyc-1]) begin
        failures++;
        $display("FAIL wr_drop_ready cyc=%0d got=%c exp=%c", cyc, obs, exp_s[cyc-1]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    string rdy_s, cmd_s;
    byte   obs_r, obs_c;
    rdy_s = ".rr...rr.w";
    cmd_s = "0011000110";
    start_fresh();
    rd_cmd = 1'b1; wr_cmd = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      sram_ready = !(cyc >= 4 && cyc <= 6);
      @(negedge clock);
      obs_r = rd_ready ? "r" : (wr_ready ? "w" : ".");
      obs_c = sram_cmd ? "1" : "0";
      checks++;
      if (obs_r !== rdy_s[cyc-1]) begin
        failures++;
        $display("FAIL stall_ready cyc=%0d got=%c exp=%c", cyc, obs_r, rdy_s[cyc-1]);
      end
      checks++;
      if (obs_c !== cmd_s[cyc-1]) begin
        failures++;
        $display("FAIL stall_cmd cyc=%0d got=%c exp=%c", cyc, obs_c, cmd_s[cyc-1]);
      end
      tick();
    end
    sram_ready = 1'b1;
  endtask

  task automatic test_rvalid();
    start_fresh();
    wr_cmd = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      sram_rvalid = (cyc == 3);
      sram_rdata  = (cyc == 3) ? 32'h0000_00A5 : 32'h0;
      sram_rtag   = (cyc == 3) ? 2'd1 : 2'd0;
      @(negedge clock);
      if (cyc == 3) begin
        checks++;
        if (wr_ready !== 1'b1) begin
          failures++; $display("FAIL rvalid_in_grant_wr got=%b exp=1", wr_ready);
        end
      end
      if (cyc >= 2) begin
        checks++;
        if (rd_valid !== (cyc == 4)) begin
          failures++; $display("FAIL rvalid_timing cyc=%0d got=%b exp=%b", cyc, rd_valid, cyc == 4);
        end
      end
      if (cyc == 4) begin
        checks++;
        if ({rd_data, rd_qtag} !== {32'h0000_00A5, 2'd1}) begin
          failures++; $display("FAIL rvalid_payload got=%h/%0d exp=a5/1", rd_data, rd_qtag);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [104:0] obs;
    start_fresh();
    wr_cmd = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      reset       = (cyc == 4);
      sram_rvalid = (cyc == 4);
      sram_rdata  = 32'h0000_1234; sram_rtag = 2'd3;
      wr_addr = $urandom | 32'h1; wr_data = $urandom | 32'h1;
      @(negedge clock);
      if (cyc == 4) begin
        checks++;
        if (wr_ready !== 1'b1) begin
          failures++; $display("FAIL reset_mid_accept got=%b exp=1", wr_ready);
        end
      end
      if (cyc == 5) begin
        obs = {sram_cmd, sram_we, sram_addr, sram_wdata, sram_tag,
               rd_valid, rd_data, rd_qtag, rd_ready, wr_ready};
        checks++;
        if (obs !== 105'd0) begin
          failures++; $display("FAIL reset_mid_outputs got=%h exp=0", obs);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (wr_ready !== 1'b1) begin
          failures++; $display("FAIL reset_mid_regrant got=%b exp=1", wr_ready);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    start_fresh();
    for (int c = 0; c < 800; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      rd_cmd      = ($urandom_range(0, 9) < 6);
      wr_cmd      = ($urandom_range(0, 9) < 6);
      sram_ready  = ($urandom_range(0, 9) < 8);
      sram_rvalid = ($urandom_range(0, 9) < 3);
      rd_addr = $urandom; wr_addr = $urandom; wr_data = $urandom; sram_rdata = $urandom;
      rd_tag = TW'($urandom); sram_rtag = TW'($urandom);
      @(negedge clock);
      checks++;
      if ({rd_ready, wr_ready, sram_cmd} !== {m_rd_rdy(), m_wr_rdy(), e_cmd}) begin
        failures++;
        $display("FAIL rnd_handshake c=%0d got=%b exp=%b", c, {rd_ready, wr_ready, sram_cmd},
                 {m_rd_rdy(), m_wr_rdy(), e_cmd});
      end
      if (e_cmd) begin
        checks++;
        if ({sram_we, sram_addr, sram_tag} !== {e_we, e_addr, e_tag} ||
            (e_we && sram_wdata !== e_wdata)) begin
          failures++;
          $display("FAIL rnd_payload c=%0d got we=%b a=%h d=%h t=%0d exp we=%b a=%h d=%h t=%0d",
                   c, sram_we, sram_addr, sram_wdata, sram_tag, e_we, e_addr, e_wdata, e_tag);
        end
      end
      checks++;
      if ({rd_valid, rd_data, rd_qtag} !== {e_rv, e_rdata, e_rq}) begin
        failures++;
        $display("FAIL rnd_return c=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, rd_valid, rd_data,
                 rd_qtag, e_rv, e_rdata, e_rq);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    test_reset();
    test_read_stream();
    test_both_hold();
    test_write_drop();
    test_stall();
    test_rvalid();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
